mdu_e: RTL and testbench
========================

Name: mdu_E

Overview:
- Multiply/divide unit in the E stage, beside the ALU, fed the same forwarded SrcA/SrcB operands.
- Executes mult/multu/div/divu/mthi/mtlo with multi-cycle latency and owns the HI/LO registers.
- HI/LO are muxed with ALUresult into the E/M pipeline register for mfhi/mflo.
- busy goes to the D-stage hazard unit, which stalls any following MD instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  qualifies MDop; an op is accepted only when start=1.
- MDop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; others = none.
- SrcA  input  32  rs operand, already forwarded.
- SrcB  input  32  rt operand, already forwarded.
- busy  output  1  registered; 1 while a mult/div is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, count=0, busy=0, HI=0, LO=0, pending results cleared. Reset wins over every other input, including mid-operation; an in-flight result is discarded.
- States: IDLE and RUN; count is a 4-bit down-counter.
- Accept rule: an op is accepted only when state=IDLE and start=1. start while RUN is ignored, with no state change; the hazard unit guarantees this does not happen, and the bench checks it.
- mthi/mtlo (IDLE, start=1): HI<=SrcA or LO<=SrcA at that edge; visible next cycle; busy stays 0; no RUN entry.
- mult/multu/div/divu accepted at edge T:
  - Compute the result from SrcA/SrcB sampled at T and hold it in internal tmp_hi/tmp_lo; HI/LO unchanged during RUN.
  - State=RUN, count=N-1 (N = MULT_CYCLES or DIV_CYCLES), so busy=1 from T+1 through T+N.
  - At the edge where count==0 in RUN: HI<=tmp_hi, LO<=tmp_lo, state=IDLE, busy=0. New values are visible from T+N+1, the same cycle busy first reads 0.
  - A new op may be accepted in the same cycle busy reads 0.
- mult: signed 32x32 -> 64, {HI,LO}=product. multu: unsigned.
- div:
  - LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (SrcB=0, div or divu): still busy DIV_CYCLES; HI/LO left unchanged at commit.
- N=1: busy high for exactly one cycle (T+1); commit at edge T+1.
- Reading HI/LO while busy=1 returns the old values; the hazard unit stalls mfhi/mflo while busy.
- MDop=0 or an undefined code with start=1: no effect.
- No combinational path from inputs to busy, HI or LO.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MDop 7..10 are legal and take MULT_CYCLES.
  - madd/maddu: {HI,LO} <= {HI,LO} + product, with signed or unsigned product respectively.
  - msub/msubu: {HI,LO} <= {HI,LO} - product.
  - Accumulation is modulo 2^64, using the HI/LO value at the accept edge.
- Not defined: MDop 7..10 are treated as none, with no state change and busy=0; no accumulator datapath is synthesized.

Test Plan:
- Reset with HI/LO previously nonzero, reset=0 for 1 cycle -> HI=0, LO=0, busy=0; reset=0 asserted mid-div -> busy=0 next cycle, HI/LO=0, no later commit.
- mult SrcA=0xFFFFFFFE (-2), SrcB=0x00000003 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div SrcA=0xFFFFFFF9 (-7), SrcB=2 -> busy exactly 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- div by 0 with HI=0x11, LO=0x22 -> busy 10 cycles, then HI=0x11, LO=0x22. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0xDEADBEEF -> HI=0xDEADBEEF next cycle, busy never set. A second mult start while busy -> ignored, and the first result commits on schedule. Back-to-back mult accepted on the cycle busy falls -> second result commits 5 cycles later.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu 1x1 -> HI=1, LO=0. Without the macro: same stimulus -> HI/LO unchanged, busy=0.

Source files
------------

// File: rtl/mdu_e_if.sv
// Operand/result bundle between the E-stage pipeline and the multiply/divide unit.
interface mdu_e_if;
  logic        start;
  logic [3:0]  MDop;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, MDop, SrcA, SrcB, input busy, HI, LO);
  modport slave  (input start, MDop, SrcA, SrcB, output busy, HI, LO);
endinterface

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit owning HI/LO; results commit after a fixed busy window.
// Optional madd/maddu/msub/msubu accumulation is enabled by defining MDU_MADD_EN.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  mdu_e_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic        busy_q, busy_nxt;
  logic [31:0] hi_q, hi_nxt, lo_q, lo_nxt;
  logic [31:0] tmp_hi, tmp_hi_nxt, tmp_lo, tmp_lo_nxt;
  logic        commit_q, commit_nxt;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, bs_safe, bu_safe;
  logic [31:0] qs_mag, rs_mag, q_s, r_s, q_u, r_u;
  logic        launch_mult, launch_div;

  assign prod_s = $unsigned($signed({{32{bus.SrcA[31]}}, bus.SrcA}) *
                            $signed({{32{bus.SrcB[31]}}, bus.SrcB}));
  assign prod_u = {32'd0, bus.SrcA} * {32'd0, bus.SrcB};

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
  assign a_neg    = bus.SrcA[31];
  assign b_neg    = bus.SrcB[31];
  assign div_zero = (bus.SrcB == 32'd0);
  assign a_mag    = a_neg ? -bus.SrcA : bus.SrcA;
  assign b_mag    = b_neg ? -bus.SrcB : bus.SrcB;
  assign bs_safe  = div_zero ? 32'd1 : b_mag;
  assign bu_safe  = div_zero ? 32'd1 : bus.SrcB;
  assign qs_mag   = a_mag / bs_safe;
  assign rs_mag   = a_mag % bs_safe;
  assign q_s      = (a_neg ^ b_neg) ? -qs_mag : qs_mag;
  assign r_s      = a_neg ? -rs_mag : rs_mag;
  assign q_u      = bus.SrcA / bu_safe;
  assign r_u      = bus.SrcA % bu_safe;

`ifdef MDU_MADD_EN
  logic [63:0] acc_base;
  assign acc_base = {hi_q, lo_q};
`endif

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    tmp_hi_nxt  = tmp_hi;
    tmp_lo_nxt  = tmp_lo;
    commit_nxt  = commit_q;
    launch_mult = 1'b0;
    launch_div  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.MDop)
            4'd1: begin
              {tmp_hi_nxt, tmp_lo_nxt} = prod_s;
              launch_mult = 1'b1;
            end
            4'd2: begin
              {tmp_hi_nxt, tmp_lo_nxt} = prod_u;
              launch_mult = 1'b1;
            end
            4'd3: begin
              tmp_hi_nxt = r_s;
              tmp_lo_nxt = q_s;
              launch_div = 1'b1;
            end
            4'd4: begin
              tmp_hi_nxt = r_u;
              tmp_lo_nxt = q_u;
              launch_div = 1'b1;
            end
            4'd5: hi_nxt = bus.SrcA;
            4'd6: lo_nxt = bus.SrcA;
`ifdef MDU_MADD_EN
            4'd7: begin
              {tmp_hi_nxt, tmp_lo_nxt} = acc_base + prod_s;
              launch_mult = 1'b1;
            end
            4'd8: begin
              {tmp_hi_nxt, tmp_lo_nxt} = acc_base + prod_u;
              launch_mult = 1'b1;
            end
            4'd9: begin
              {tmp_hi_nxt, tmp_lo_nxt} = acc_base - prod_s;
              launch_mult = 1'b1;
            end
            4'd10: begin
              {tmp_hi_nxt, tmp_lo_nxt} = acc_base - prod_u;
              launch_mult = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        if (launch_mult) begin
          state_nxt  = RUN;
          count_nxt  = MULT_LAST;
          commit_nxt = 1'b1;
        end else if (launch_div) begin
          state_nxt  = RUN;
          count_nxt  = DIV_LAST;
          commit_nxt = !div_zero;
        end
      end
      RUN: begin
        if (count == 4'd0) begin
          if (commit_q) begin
            hi_nxt = tmp_hi;
            lo_nxt = tmp_lo;
          end
          state_nxt = IDLE;
        end else begin
          count_nxt = count - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi   <= 32'd0;
      tmp_lo   <= 32'd0;
      commit_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      busy_q   <= busy_nxt;
      hi_q     <= hi_nxt;
      lo_q     <= lo_nxt;
      tmp_hi   <= tmp_hi_nxt;
      tmp_lo   <= tmp_lo_nxt;
      commit_q <= commit_nxt;
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// Directed-vector bench for mdu_e: table of ops with expected HI/LO and busy length,
// plus hand sequences for reset, ignored start and back-to-back issue.
module tb_mdu_e;

  logic clk;
  logic reset;
  mdu_e_if bus();

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the op is presented to exactly one rising edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.MDop  = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.MDop  = 4'd0;
  endtask

  task automatic waitIdle(input logic [31:0] old_hi, input logic [31:0] old_lo, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy) break;
      cycles++;
      if (cycles == 1) begin
        checkOutput("hold_hi", bus.HI, old_hi);
        checkOutput("hold_lo", bus.LO, old_lo);
      end
      if (cycles > 40) begin
        checks++;
        errors++;
        $display("[TB] FAIL busy_timeout: got busy after %0d cycles, expected release", cycles);
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int cyc2;
    logic [31:0] oh, ol;

    vecs.push_back(vec_t'{4'd1, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    vecs.push_back(vec_t'{4'd2, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 5});
    vecs.push_back(vec_t'{4'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back(vec_t'{4'd4, 32'h7, 32'h2, 32'h1, 32'h3, 10});
    vecs.push_back(vec_t'{4'd5, 32'h11, 32'h0, 32'h11, 32'h3, 0});
    vecs.push_back(vec_t'{4'd6, 32'h22, 32'h0, 32'h11, 32'h22, 0});
    vecs.push_back(vec_t'{4'd3, 32'h5, 32'h0, 32'h11, 32'h22, 10});
    vecs.push_back(vec_t'{4'd4, 32'h5, 32'h0, 32'h11, 32'h22, 10});
    vecs.push_back(vec_t'{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10});
    vecs.push_back(vec_t'{4'd5, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h80000000, 0});
    vecs.push_back(vec_t'{4'd0, 32'h1234, 32'h5678, 32'hDEADBEEF, 32'h80000000, 0});
    vecs.push_back(vec_t'{4'd15, 32'h1234, 32'h5678, 32'hDEADBEEF, 32'h80000000, 0});
    vecs.push_back(vec_t'{4'd1, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5});
    vecs.push_back(vec_t'{4'd3, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10});
    vecs.push_back(vec_t'{4'd5, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFD, 0});
    vecs.push_back(vec_t'{4'd6, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0});
`ifdef MDU_MADD_EN
    vecs.push_back(vec_t'{4'd8, 32'h1, 32'h1, 32'h1, 32'h0, 5});
    vecs.push_back(vec_t'{4'd9, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 5});
    vecs.push_back(vec_t'{4'd7, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFE, 5});
`else
    vecs.push_back(vec_t'{4'd8, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 0});
    vecs.push_back(vec_t'{4'd9, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 0});
    vecs.push_back(vec_t'{4'd7, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 0});
`endif

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.MDop  = 4'd0;
    bus.SrcA  = 32'd0;
    bus.SrcB  = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_hi", bus.HI, 32'd0);
    checkOutput("reset_lo", bus.LO, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      oh = bus.HI;
      ol = bus.LO;
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitIdle(oh, ol, cyc);
      checkOutput($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
      checkOutput($sformatf("vec%0d_hi", i), bus.HI, vecs[i].hi);
      checkOutput($sformatf("vec%0d_lo", i), bus.LO, vecs[i].lo);
    end

    // Reset while HI/LO hold nonzero values.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("rst1_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst1_hi", bus.HI, 32'd0);
    checkOutput("rst1_lo", bus.LO, 32'd0);

    // Reset mid-divide: the in-flight result must never land.
    applyStimulus(4'd5, 32'h55, 32'h0);
    @(negedge clk);
    applyStimulus(4'd6, 32'h66, 32'h0);
    @(negedge clk);
    applyStimulus(4'd4, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    checkOutput("rst2_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("rst2_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst2_hi", bus.HI, 32'd0);
    checkOutput("rst2_lo", bus.LO, 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("rst2_late_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst2_late_hi", bus.HI, 32'd0);
    checkOutput("rst2_late_lo", bus.LO, 32'd0);

    // Second start while busy must be ignored.
    applyStimulus(4'd1, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    checkOutput("ign_busy", {31'd0, bus.busy}, 32'd1);
    applyStimulus(4'd1, 32'd5, 32'd5);
    waitIdle(32'd0, 32'd0, cyc);
    checkOutput("ign_cycles", 32'(cyc + 2), 32'd5);
    checkOutput("ign_hi", bus.HI, 32'd0);
    checkOutput("ign_lo", bus.LO, 32'd12);
    repeat (3) @(negedge clk);
    checkOutput("ign_after_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("ign_after_lo", bus.LO, 32'd12);

    // Back-to-back: second mult issued in the first cycle busy reads 0.
    applyStimulus(4'd1, 32'd2, 32'd3);
    waitIdle(32'd0, 32'd12, cyc);
    checkOutput("b2b_first_cycles", 32'(cyc), 32'd5);
    checkOutput("b2b_first_lo", bus.LO, 32'd6);
    applyStimulus(4'd1, 32'd4, 32'd5);
    waitIdle(32'd0, 32'd6, cyc2);
    checkOutput("b2b_second_cycles", 32'(cyc2), 32'd5);
    checkOutput("b2b_second_hi", bus.HI, 32'd0);
    checkOutput("b2b_second_lo", bus.LO, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
